// File: rtl/signal_conflict_monitor_if.sv
// Lamp request/drive bundle between a traffic controller and the conflict monitor.
// The controller side uses the master modport, the monitor uses slave.
interface signal_conflict_monitor_if;
   logic grn1;
   logic ylw1;
   logic red1;
   logic grn2;
   logic ylw2;
   logic red2;
   logic lgrn1;
   logic lylw1;
   logic lred1;
   logic lgrn2;
   logic lylw2;
   logic lred2;
   logic fault;
   logic [2:0] fcode;
   logic flash;

   modport master (
      output grn1, ylw1, red1, grn2, ylw2, red2,
      input  lgrn1, lylw1, lred1, lgrn2, lylw2, lred2, fault, fcode, flash
   );

   modport slave (
      input  grn1, ylw1, red1, grn2, ylw2, red2,
      output lgrn1, lylw1, lred1, lgrn2, lylw2, lred2, fault, fcode, flash
   );
endinterface

// File: rtl/signal_conflict_monitor.sv
// Two-phase traffic signal conflict monitor: registered lamp pass-through with fail-safe red flash lock-out.
// Optional MONITOR_FAULT_COUNT_EN adds fcnt, a saturating lock-out entry counter that survives clr.
module signal_conflict_monitor #(
   parameter int PERSIST    = 3,
   parameter int FLASH_HALF = 8
) (
   input logic ck,
   input logic clr,
   signal_conflict_monitor_if.slave mon
`ifdef MONITOR_FAULT_COUNT_EN
   ,
   output logic [7:0] fcnt
`endif
);

   typedef enum logic [1:0] {
      RUN,
      PEND,
      LOCK
   } monitorState_t;

   localparam logic [3:0] PERSIST_L  = 4'(PERSIST);
   localparam logic [7:0] FLASH_LAST = 8'(FLASH_HALF - 1);
   localparam logic [5:0] LAMPS_REDS = 6'b001001;

   monitorState_t stateQ, stateNext;
   logic [3:0] pcQ, pcNext;
   logic [7:0] fcQ, fcNext;
   logic       faultQ, faultNext;
   logic [2:0] fcodeQ, fcodeNext;
   logic       flashQ, flashNext;
   logic [5:0] lampQ, lampNext;
   logic [5:0] reqLamps;
   logic [2:0] faultCode;
   logic       multi1, multi2;
   logic       lockEntry;

   assign reqLamps = {mon.grn1, mon.ylw1, mon.red1, mon.grn2, mon.ylw2, mon.red2};

   // Highest-priority conflict present on the requests this cycle, 0 when clean.
   always_comb begin
      multi1 = (mon.grn1 & mon.ylw1) | (mon.grn1 & mon.red1) | (mon.ylw1 & mon.red1);
      multi2 = (mon.grn2 & mon.ylw2) | (mon.grn2 & mon.red2) | (mon.ylw2 & mon.red2);
      faultCode = 3'd0;
      if (mon.grn1 & mon.grn2) begin
         faultCode = 3'd1;
      end else if (!(mon.grn1 | mon.ylw1 | mon.red1)) begin
         faultCode = 3'd2;
      end else if (!(mon.grn2 | mon.ylw2 | mon.red2)) begin
         faultCode = 3'd3;
      end else if (multi1 | multi2) begin
         faultCode = 3'd4;
      end
   end

   // Next-state logic; entering LOCK forces reds lit and greens/yellows dark on that same edge.
   always_comb begin
      stateNext = stateQ;
      pcNext    = pcQ;
      fcNext    = fcQ;
      faultNext = faultQ;
      fcodeNext = fcodeQ;
      flashNext = flashQ;
      lampNext  = lampQ;
      lockEntry = 1'b0;
      case (stateQ)
         RUN, PEND: begin
            lampNext  = reqLamps;
            faultNext = 1'b0;
            fcodeNext = 3'd0;
            flashNext = 1'b0;
            if (faultCode != 3'd0) begin
               if ((stateQ == RUN) ? (PERSIST_L == 4'd1) : ((pcQ + 4'd1) == PERSIST_L)) begin
                  lockEntry = 1'b1;
                  stateNext = LOCK;
                  pcNext    = 4'd0;
                  fcNext    = 8'd0;
                  faultNext = 1'b1;
                  fcodeNext = faultCode;
                  flashNext = 1'b1;
                  lampNext  = LAMPS_REDS;
               end else begin
                  stateNext = PEND;
                  pcNext    = (stateQ == RUN) ? 4'd1 : pcQ + 4'd1;
               end
            end else begin
               stateNext = RUN;
               pcNext    = 4'd0;
            end
         end
         LOCK: begin
            if (fcQ == FLASH_LAST) begin
               fcNext    = 8'd0;
               flashNext = ~flashQ;
            end else begin
               fcNext = fcQ + 8'd1;
            end
            lampNext = {2'b00, flashNext, 2'b00, flashNext};
         end
         default: begin
            stateNext = RUN;
            pcNext    = 4'd0;
         end
      endcase
   end

   // State register; clr overrides everything, including a lock entry on the same edge.
   always_ff @(posedge ck) begin
      if (clr) begin
         stateQ <= RUN;
         pcQ    <= 4'd0;
         fcQ    <= 8'd0;
         faultQ <= 1'b0;
         fcodeQ <= 3'd0;
         flashQ <= 1'b0;
         lampQ  <= LAMPS_REDS;
      end else begin
         stateQ <= stateNext;
         pcQ    <= pcNext;
         fcQ    <= fcNext;
         faultQ <= faultNext;
         fcodeQ <= fcodeNext;
         flashQ <= flashNext;
         lampQ  <= lampNext;
      end
   end

`ifdef MONITOR_FAULT_COUNT_EN
   logic [7:0] fcntQ = 8'd0;

   // Only the power-up value clears this count, so it records lock-outs across clr.
   always_ff @(posedge ck) begin
      if (!clr && lockEntry && (fcntQ != 8'hFF)) begin
         fcntQ <= fcntQ + 8'd1;
      end
   end

   assign fcnt = fcntQ;
`endif

   assign mon.lgrn1 = lampQ[5];
   assign mon.lylw1 = lampQ[4];
   assign mon.lred1 = lampQ[3];
   assign mon.lgrn2 = lampQ[2];
   assign mon.lylw2 = lampQ[1];
   assign mon.lred2 = lampQ[0];
   assign mon.fault = faultQ;
   assign mon.fcode = fcodeQ;
   assign mon.flash = flashQ;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed bench for signal_conflict_monitor: dutA uses PERSIST=3, dutB PERSIST=1, both FLASH_HALF=4.
// Lamp vectors are packed {g1,y1,r1,g2,y2,r2}.
module tb_signal_conflict_monitor;

   localparam logic [5:0] G1R2  = 6'b100001;
   localparam logic [5:0] Y1R2  = 6'b010001;
   localparam logic [5:0] R1G2  = 6'b001100;
   localparam logic [5:0] G1G2  = 6'b100100;
   localparam logic [5:0] DARK1 = 6'b000011;
   localparam logic [5:0] REDS  = 6'b001001;

   logic ck = 1'b0;
   logic clr;
   int   passCount = 0;
   int   checkCount = 0;
   int   expEntriesA = 0;

   signal_conflict_monitor_if ifA ();
   signal_conflict_monitor_if ifB ();

   logic [5:0] lampsA, lampsB;
   assign lampsA = {ifA.lgrn1, ifA.lylw1, ifA.lred1, ifA.lgrn2, ifA.lylw2, ifA.lred2};
   assign lampsB = {ifB.lgrn1, ifB.lylw1, ifB.lred1, ifB.lgrn2, ifB.lylw2, ifB.lred2};

`ifdef MONITOR_FAULT_COUNT_EN
   logic [7:0] fcntA, fcntB;
`endif

   always #5 ck = ~ck;

   signal_conflict_monitor #(.PERSIST(3), .FLASH_HALF(4)) dutA (
      .ck  (ck),
      .clr (clr),
      .mon (ifA)
`ifdef MONITOR_FAULT_COUNT_EN
      ,
      .fcnt(fcntA)
`endif
   );

   signal_conflict_monitor #(.PERSIST(1), .FLASH_HALF(4)) dutB (
      .ck  (ck),
      .clr (clr),
      .mon (ifB)
`ifdef MONITOR_FAULT_COUNT_EN
      ,
      .fcnt(fcntB)
`endif
   );

   // Drive both monitors, then step one edge and settle before sampling.
   task automatic applyStimulus(input logic [5:0] pat, input logic c);
      clr = c;
      {ifA.grn1, ifA.ylw1, ifA.red1, ifA.grn2, ifA.ylw2, ifA.red2} = pat;
      {ifB.grn1, ifB.ylw1, ifB.red1, ifB.grn2, ifB.ylw2, ifB.red2} = pat;
      @(posedge ck);
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(G1G2, 1'b1);
      applyStimulus(G1G2, 1'b1);
      checkCount++;
      if ({lampsA, ifA.fault, ifA.fcode, ifA.flash} !== {REDS, 1'b0, 3'd0, 1'b0})
         $display("[TB] FAIL reset_A got %b want %b", {lampsA, ifA.fault, ifA.fcode, ifA.flash}, {REDS, 1'b0, 3'd0, 1'b0});
      else passCount++;
      checkCount++;
      if ({lampsB, ifB.fault, ifB.fcode, ifB.flash} !== {REDS, 1'b0, 3'd0, 1'b0})
         $display("[TB] FAIL reset_B got %b want %b", {lampsB, ifB.fault, ifB.fcode, ifB.flash}, {REDS, 1'b0, 3'd0, 1'b0});
      else passCount++;
   endtask

   task automatic test_passthrough();
      logic [5:0] seq [3];
      seq[0] = G1R2;
      seq[1] = Y1R2;
      seq[2] = R1G2;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(seq[i], 1'b0);
         checkCount++;
         if ({lampsA, ifA.fault} !== {seq[i], 1'b0})
            $display("[TB] FAIL pass_A[%0d] got %b want %b", i, {lampsA, ifA.fault}, {seq[i], 1'b0});
         else passCount++;
         checkCount++;
         if ({lampsB, ifB.fault} !== {seq[i], 1'b0})
            $display("[TB] FAIL pass_B[%0d] got %b want %b", i, {lampsB, ifB.fault}, {seq[i], 1'b0});
         else passCount++;
      end
   endtask

   task automatic test_persist();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(G1G2, 1'b0);
         checkCount++;
         if ({lampsA, ifA.fault, ifA.fcode} !== {G1G2, 1'b0, 3'd0})
            $display("[TB] FAIL pend_A[%0d] got %b want %b", i, {lampsA, ifA.fault, ifA.fcode}, {G1G2, 1'b0, 3'd0});
         else passCount++;
      end
      applyStimulus(G1R2, 1'b0);
      checkCount++;
      if ({lampsA, ifA.fault} !== {G1R2, 1'b0})
         $display("[TB] FAIL two_faults_A got %b want %b", {lampsA, ifA.fault}, {G1R2, 1'b0});
      else passCount++;
      for (int i = 0; i < 3; i++) applyStimulus(G1G2, 1'b0);
      expEntriesA++;
      checkCount++;
      if ({lampsA, ifA.fault, ifA.fcode, ifA.flash} !== {REDS, 1'b1, 3'd1, 1'b1})
         $display("[TB] FAIL lock_A got %b want %b", {lampsA, ifA.fault, ifA.fcode, ifA.flash}, {REDS, 1'b1, 3'd1, 1'b1});
      else passCount++;
   endtask

   task automatic test_flash();
      logic       expRed;
      logic [5:0] expLamps;
      for (int k = 1; k <= 11; k++) begin
         applyStimulus(G1R2, 1'b0);
         expRed   = ((k / 4) % 2) == 0;
         expLamps = {2'b00, expRed, 2'b00, expRed};
         checkCount++;
         if ({lampsA, ifA.fault, ifA.fcode, ifA.flash} !== {expLamps, 1'b1, 3'd1, expRed})
            $display("[TB] FAIL flash_A[%0d] got %b want %b", k, {lampsA, ifA.fault, ifA.fcode, ifA.flash}, {expLamps, 1'b1, 3'd1, expRed});
         else passCount++;
      end
   endtask

   task automatic test_clear();
      applyStimulus(G1R2, 1'b1);
      checkCount++;
      if ({lampsA, ifA.fault, ifA.fcode, ifA.flash} !== {REDS, 1'b0, 3'd0, 1'b0})
         $display("[TB] FAIL clear_A got %b want %b", {lampsA, ifA.fault, ifA.fcode, ifA.flash}, {REDS, 1'b0, 3'd0, 1'b0});
      else passCount++;
      applyStimulus(R1G2, 1'b0);
      checkCount++;
      if ({lampsA, ifA.fault} !== {R1G2, 1'b0})
         $display("[TB] FAIL resume_A got %b want %b", {lampsA, ifA.fault}, {R1G2, 1'b0});
      else passCount++;
   endtask

   task automatic test_priority();
      applyStimulus(DARK1, 1'b0);
      checkCount++;
      if ({lampsB, ifB.fault, ifB.fcode} !== {REDS, 1'b1, 3'd2})
         $display("[TB] FAIL prio_B_first got %b want %b", {lampsB, ifB.fault, ifB.fcode}, {REDS, 1'b1, 3'd2});
      else passCount++;
      checkCount++;
      if ({lampsA, ifA.fault} !== {DARK1, 1'b0})
         $display("[TB] FAIL prio_A_first got %b want %b", {lampsA, ifA.fault}, {DARK1, 1'b0});
      else passCount++;
      applyStimulus(DARK1, 1'b0);
      applyStimulus(DARK1, 1'b0);
      expEntriesA++;
      checkCount++;
      if ({lampsA, ifA.fault, ifA.fcode} !== {REDS, 1'b1, 3'd2})
         $display("[TB] FAIL prio_A_lock got %b want %b", {lampsA, ifA.fault, ifA.fcode}, {REDS, 1'b1, 3'd2});
      else passCount++;
   endtask

   task automatic test_codes();
      logic [5:0] pats  [4];
      logic [2:0] codes [4];
      pats[0] = 6'b100000; codes[0] = 3'd3;
      pats[1] = 6'b110001; codes[1] = 3'd4;
      pats[2] = 6'b100110; codes[2] = 3'd1;
      pats[3] = 6'b000000; codes[3] = 3'd2;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(G1R2, 1'b1);
         applyStimulus(pats[i], 1'b0);
         checkCount++;
         if ({ifB.fault, ifB.fcode} !== {1'b1, codes[i]})
            $display("[TB] FAIL code_B[%0d] got %b want %b", i, {ifB.fault, ifB.fcode}, {1'b1, codes[i]});
         else passCount++;
      end
   endtask

   task automatic test_clr_collision();
      applyStimulus(G1R2, 1'b1);
      applyStimulus(G1G2, 1'b0);
      applyStimulus(G1G2, 1'b0);
      applyStimulus(G1G2, 1'b1);
      checkCount++;
      if ({lampsA, ifA.fault, ifA.fcode, ifA.flash} !== {REDS, 1'b0, 3'd0, 1'b0})
         $display("[TB] FAIL collide_A got %b want %b", {lampsA, ifA.fault, ifA.fcode, ifA.flash}, {REDS, 1'b0, 3'd0, 1'b0});
      else passCount++;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(G1G2, 1'b0);
         checkCount++;
         if ({lampsA, ifA.fault} !== {G1G2, 1'b0})
            $display("[TB] FAIL restart_A[%0d] got %b want %b", i, {lampsA, ifA.fault}, {G1G2, 1'b0});
         else passCount++;
      end
      applyStimulus(G1R2, 1'b0);
   endtask

`ifdef MONITOR_FAULT_COUNT_EN
   task automatic test_fcnt();
      for (int n = 0; n < 3; n++) begin
         applyStimulus(G1R2, 1'b1);
         for (int i = 0; i < 3; i++) applyStimulus(G1G2, 1'b0);
         expEntriesA++;
      end
      applyStimulus(G1R2, 1'b1);
      checkCount++;
      if (fcntA !== 8'(expEntriesA))
         $display("[TB] FAIL fcnt_A got %0d want %0d", fcntA, expEntriesA);
      else passCount++;
      for (int n = 0; n < 256; n++) begin
         applyStimulus(G1G2, 1'b0);
         applyStimulus(G1R2, 1'b1);
      end
      checkCount++;
      if (fcntB !== 8'd255)
         $display("[TB] FAIL fcnt_B_sat got %0d want 255", fcntB);
      else passCount++;
   endtask
`endif

   initial begin
      test_reset();
      test_passthrough();
      test_persist();
      test_flash();
      test_clear();
      test_priority();
      test_codes();
      test_clr_collision();
`ifdef MONITOR_FAULT_COUNT_EN
      test_fcnt();
`endif
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/signal_conflict_monitor.md
SIGNAL_CONFLICT_MONITOR -- requirements
Module: signal_conflict_monitor

Interface
REQ-001 SHALL have parameter PERSIST, default 3, number of consecutive faulty cycles before lock-out (legal 1..15).
REQ-002 SHALL have parameter FLASH_HALF, default 8, half-period of fail-safe red flash in CK cycles (legal 1..255).
REQ-003 SHALL have one clock; reset is synchronous and active-high: CK input 1 clock; CLR input 1 synchronous active-high reset.
REQ-004 GRN1, YLW1, RED1  input  1 each  phase-1 lamp requests from the traffic controller.
REQ-005 GRN2, YLW2, RED2  input  1 each  phase-2 lamp requests from the traffic controller.
REQ-006 LGRN1, LYLW1, LRED1, LGRN2, LYLW2, LRED2  output  1 each  registered lamp drives.
REQ-007 FAULT  output  1  high while locked out.
REQ-008 FCODE  output  3  latched fault code, 0 = none.
REQ-009 FLASH  output  1  current fail-safe flash phase, 1 = reds lit.

Function
REQ-010 Fault conditions are evaluated on sampled inputs each cycle, priority high to low: code 1 = GRN1&GRN2; code 2 = no lamp on phase 1; code 3 = no lamp on phase 2; code 4 = more than one of G/Y/R on either phase.
REQ-011 FSM states RUN, PEND, LOCK; a 4-bit persistence counter PC; an 8-bit flash counter FC.
REQ-012 RUN: lamp outputs equal the inputs sampled at the same edge (1-cycle latency); fault present and PERSIST=1 -> LOCK; fault present and PERSIST>1 -> PEND with PC=1.
REQ-013 PEND: pass-through continues; fault present -> PC+1, and when PC+1 equals PERSIST -> LOCK; fault absent -> RUN, PC=0.
REQ-014 The fault code may change while in PEND without restarting PC; any faulty cycle counts.
REQ-015 On entry to LOCK: FCODE latches the highest-priority code of the entering cycle; FAULT=1; FLASH=1; FC=0; all greens and yellows 0; LRED1=LRED2=FLASH from that edge on.
REQ-016 LOCK: FC increments each cycle; when FC reaches FLASH_HALF-1, FC wraps to 0 and FLASH toggles; so reds alternate FLASH_HALF cycles on and FLASH_HALF cycles off.
REQ-017 LOCK is exited only by CLR; input activity, including fault clearing, is ignored.
REQ-018 Fault conditions are not evaluated in a cycle where CLR=1.
REQ-019 FCODE holds 0 in RUN and PEND.

Reset
REQ-020 CLR=1 at a CK edge SHALL force state RUN, PC=0, FC=0, FAULT=0, FCODE=0, FLASH=0, LRED1=LRED2=1, all other lamp outputs 0, overriding every other event including a LOCK entry in the same cycle.
REQ-021 In the first edge after CLR falls, pass-through resumes and fault evaluation restarts from PC=0.

Configuration
REQ-022 Macro MONITOR_FAULT_COUNT_EN: when defined, adds output FCNT (8 bits), a saturating count of LOCK entries. It is not cleared by CLR and is cleared only by power-up initial value 0. It increments once per LOCK entry and holds at 255.
REQ-023 Without MONITOR_FAULT_COUNT_EN, port FCNT and its register are absent; all other behaviour is identical.

Verification
REQ-024 CLR high 2 cycles, then legal sequence G1/R2 -> Y1/R2 -> R1/G2 -> expect each lamp output equal to the input one cycle later, FAULT=0 throughout.
REQ-025 PERSIST=3: GRN1=GRN2=1 for 2 cycles then legal -> stays RUN, FAULT=0; same for 3 cycles -> FAULT=1, FCODE=1, all greens 0, LRED1=LRED2=1 on the edge sampling the third fault.
REQ-026 FLASH_HALF=4 in LOCK -> reds 1 for 4 cycles, 0 for 4, 1 for 4; inputs returned legal -> FAULT stays 1 until CLR.
REQ-027 Phase 1 dark (G1=Y1=R1=0) plus Y2&R2 both set for 3 cycles -> FCODE=2 (priority over code 4); PERSIST=1 variant -> LOCK on the first faulty edge.
REQ-028 CLR asserted in the same cycle as the PERSIST-th fault -> no LOCK, outputs equal reset values, FCODE=0.
REQ-029 With MONITOR_FAULT_COUNT_EN: 3 LOCK/CLR cycles -> FCNT=3; force 256 entries -> FCNT=255.
